leaf_arbiter: RTL and testbench

Shares one router injection/ejection port among the four network interfaces (ni) of a leaf group. Round-robin arbitration with per-port buffering merges the four ni uplink streams onto a single valid/ready router link. Downlink packets are steered to the correct ni by the 2-bit leaf field of the routing header. Sits between four ni instances and one group router port.

---
 rtl/noc_pkg.sv | 20 ++
 rtl/leaf_fifo.sv | 50 +++++
 rtl/leaf_arbiter.sv | 127 ++++++++++++
 tb/tb_leaf_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC constants and header layout for the leaf group logic.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package noc_pkg;

  localparam int DATA_W     = 16;
  localparam int HEADER_W   = 6;
  localparam int GROUP_MSB  = 15;
  localparam int GROUP_LSB  = 12;
  localparam int LEAF_MSB   = 11;
  localparam int LEAF_LSB   = 10;
  localparam int NUM_LEAVES = 4;

  // Routing header as it sits in the top bits of every flit.
  typedef struct packed {
    logic [GROUP_MSB-GROUP_LSB:0] group;
    logic [LEAF_MSB-LEAF_LSB:0]   leaf;
  } hdr_t;

endpackage

// File: rtl/leaf_fifo.sv
// Small synchronous FIFO with occupancy output, one per ni uplink.
// Latency: a push at edge k is visible on head_dat after edge k.
// Backpressure: none internally; pushes into a full FIFO without a pop are ignored.
module leaf_fifo #(
  parameter int DATA_W    = 16,
  parameter int BUF_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_vld,
  input  logic [DATA_W-1:0]            push_dat,
  input  logic                         pop,
  output logic [DATA_W-1:0]            head_dat,
  output logic [$clog2(BUF_DEPTH):0]   cnt
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [BUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  // A pop only happens when something is stored; a push always fits unless full with no pop.
  assign do_pop   = pop && (cnt != '0);
  assign do_push  = push_vld && ((cnt < CNT_W'(BUF_DEPTH)) || do_pop);
  assign head_dat = mem[rd_ptr];

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks push minus pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      cnt <= cnt + 1'b1;
      else if (do_pop && !do_push) cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/leaf_arbiter.sv
// Merges four ni uplinks onto one router link (round-robin) and steers downlink flits by leaf.
// Latency: uplink 1 cycle from buffer push to up_valid_out; downlink exactly 1 cycle.
// Backpressure: up_ready_in stalls the output register; ni_ready_out throttles each ni; downlink has none.
module leaf_arbiter #(
  parameter int         NUM_PORTS = 4,
  parameter int         DATA_W    = 16,
  parameter logic [3:0] GROUP_ID  = 4'd3,
  parameter int         BUF_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_PORTS*DATA_W-1:0]   ni_data_in,
  input  logic [NUM_PORTS-1:0]          ni_valid_in,
  output logic [NUM_PORTS-1:0]          ni_ready_out,
  output logic [DATA_W-1:0]             up_data_out,
  output logic                          up_valid_out,
  input  logic                          up_ready_in,
  input  logic [DATA_W-1:0]             down_data_in,
  input  logic                          down_valid_in,
  output logic [NUM_PORTS*DATA_W-1:0]   ni_data_out,
  output logic [NUM_PORTS-1:0]          ni_valid_out,
  output logic [7:0]                    drop_count
);

  import noc_pkg::*;

  localparam int CNT_W  = $clog2(BUF_DEPTH) + 1;
  localparam int PORT_W = $clog2(NUM_PORTS);

  logic [CNT_W-1:0]  cnt  [NUM_PORTS];
  logic [DATA_W-1:0] head [NUM_PORTS];
  logic [NUM_PORTS-1:0] nonempty;
  logic [NUM_PORTS-1:0] pop;
  logic [PORT_W-1:0]    rr_ptr;
  logic [PORT_W-1:0]    grant;
  logic [PORT_W-1:0]    scan_idx;
  logic                 grant_found;
  logic                 load_ok;
  hdr_t                 dn_hdr;
  logic                 group_hit;

  // Per-port uplink buffers; ready looks ahead by the pulse already on the wire.
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    leaf_fifo #(
      .DATA_W   (DATA_W),
      .BUF_DEPTH(BUF_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push_vld (ni_valid_in[i]),
      .push_dat (ni_data_in[i*DATA_W +: DATA_W]),
      .pop      (pop[i]),
      .head_dat (head[i]),
      .cnt      (cnt[i])
    );

    assign nonempty[i]     = (cnt[i] != '0);
    assign ni_ready_out[i] = ({1'b0, cnt[i]} + {{CNT_W{1'b0}}, ni_valid_in[i]})
                             < (CNT_W+1)'(BUF_DEPTH);
  end

  assign load_ok = !up_valid_out || up_ready_in;

  // Round-robin scan from rr_ptr; walking backwards lets the nearest candidate win.
  always_comb begin
    grant_found = 1'b0;
    grant       = '0;
    scan_idx    = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      scan_idx = rr_ptr + PORT_W'(k);
      if (nonempty[scan_idx]) begin
        grant_found = 1'b1;
        grant       = scan_idx;
      end
    end
  end

  // Pop the granted head only when the output register can take it.
  always_comb begin
    pop = '0;
    if (load_ok && grant_found) pop[grant] = 1'b1;
  end

  // Output register and pointer update; data stays put while the router stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      up_data_out  <= '0;
      up_valid_out <= 1'b0;
      rr_ptr       <= '0;
    end else if (load_ok) begin
      if (grant_found) begin
        up_data_out  <= head[grant];
        up_valid_out <= 1'b1;
        rr_ptr       <= grant + 1'b1;
      end else begin
        up_valid_out <= 1'b0;
      end
    end
  end

  assign dn_hdr    = hdr_t'(down_data_in[GROUP_MSB:LEAF_LSB]);
  assign group_hit = (dn_hdr.group == GROUP_ID);

  // Downlink steering: one-cycle pulse to the addressed leaf, flit passed untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ni_valid_out <= '0;
      ni_data_out  <= '0;
    end else begin
      ni_valid_out <= '0;
      if (down_valid_in && group_hit) begin
        ni_valid_out[dn_hdr.leaf]                        <= 1'b1;
        ni_data_out[int'(dn_hdr.leaf)*DATA_W +: DATA_W]  <= down_data_in;
      end
    end
  end

  // Misrouted downlink flits are discarded and counted, saturating at 255.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_count <= '0;
    end else if (down_valid_in && !group_hit && (drop_count != 8'hFF)) begin
      drop_count <= drop_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_leaf_arbiter.sv
// Self-checking bench for leaf_arbiter: directed stimulus, queue scoreboard, negedge monitor.
// Latency: n/a.
// Backpressure: exercised via up_ready_in hold and an ni model with one-cycle ready lag.
module tb_leaf_arbiter;

  localparam int NP = 4;
  localparam int DW = 16;
  localparam int BD = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NP*DW-1:0]  ni_data_in;
  logic [NP-1:0]     ni_valid_in;
  logic [NP-1:0]     ni_ready_out;
  logic [DW-1:0]     up_data_out;
  logic              up_valid_out;
  logic              up_ready_in;
  logic [DW-1:0]     down_data_in;
  logic              down_valid_in;
  logic [NP*DW-1:0]  ni_data_out;
  logic [NP-1:0]     ni_valid_out;
  logic [7:0]        drop_count;

  int n_checks = 0;
  int n_fail   = 0;
  int up_seen  = 0;

  logic [15:0] up_q [$];
  logic [19:0] dn_q [$];   // {valid vector, flit}

  leaf_arbiter #(
    .NUM_PORTS(NP), .DATA_W(DW), .GROUP_ID(4'd3), .BUF_DEPTH(BD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ni_data_in   (ni_data_in),
    .ni_valid_in  (ni_valid_in),
    .ni_ready_out (ni_ready_out),
    .up_data_out  (up_data_out),
    .up_valid_out (up_valid_out),
    .up_ready_in  (up_ready_in),
    .down_data_in (down_data_in),
    .down_valid_in(down_valid_in),
    .ni_data_out  (ni_data_out),
    .ni_valid_out (ni_valid_out),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset         = 1'b0;
    ni_valid_in   = '0;
    ni_data_in    = '0;
    down_valid_in = 1'b0;
    down_data_in  = '0;
    up_ready_in   = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic drain(input string name, input int limit);
    for (int c = 0; c < limit && (up_q.size() != 0 || up_valid_out); c++) tick();
    check(name, up_q.size(), 0);
  endtask

  // Monitor: every accepted uplink flit and every downlink pulse is matched against the queues.
  always @(negedge clk) begin
    if (reset && up_valid_out && up_ready_in) begin
      up_seen++;
      if (up_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL up_unexpected: got %h, expected no flit", up_data_out);
      end else begin
        check("up_flit", up_data_out, up_q.pop_front());
      end
    end
    if (reset && ni_valid_out != '0) begin
      logic [15:0] d;
      d = '0;
      for (int i = 0; i < NP; i++) if (ni_valid_out[i]) d = ni_data_out[i*DW +: DW];
      if (dn_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dn_unexpected: got vec %b data %h, expected no pulse", ni_valid_out, d);
      end else begin
        check("dn_flit", {ni_valid_out, d}, dn_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic r;
    int   npush;
    int   base;

    // Reset held with traffic on every input.
    reset         = 1'b0;
    ni_valid_in   = 4'hF;
    ni_data_in    = 64'h1111_2222_3333_4444;
    down_valid_in = 1'b1;
    down_data_in  = 16'h4B21;
    up_ready_in   = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_up_valid", up_valid_out, 0);
    check("rst_ni_valid", ni_valid_out, 0);
    check("rst_ni_ready", ni_ready_out, 4'hF);
    check("rst_drop", drop_count, 0);
    check("rst_up_data", up_data_out, 0);
    do_reset();

    // Single flit on port 2: appears one cycle after the push edge.
    ni_valid_in = 4'b0100;
    ni_data_in[2*DW +: DW] = 16'h3A55;
    up_q.push_back(16'h3A55);
    tick();
    ni_valid_in = '0;
    check("single_lat0", up_valid_out, 0);
    tick();
    check("single_vld", up_valid_out, 1);
    check("single_dat", up_data_out, 16'h3A55);
    drain("single_drain", 10);

    // Fairness and throughput: two flits per port, grants must go 0,1,2,3,0,1,2,3 back to back.
    do_reset();
    base = up_seen;
    for (int s = 0; s < 2; s++)
      for (int p = 0; p < NP; p++)
        up_q.push_back(16'hA000 | 16'(p << 4) | 16'(s));
    ni_valid_in = 4'hF;
    for (int p = 0; p < NP; p++) ni_data_in[p*DW +: DW] = 16'hA000 | 16'(p << 4);
    tick();
    for (int p = 0; p < NP; p++) ni_data_in[p*DW +: DW] = 16'hA001 | 16'(p << 4);
    tick();
    ni_valid_in = '0;
    repeat (8) tick();
    check("fair_count", up_seen - base, 8);
    check("fair_idle", up_valid_out, 0);
    drain("fair_drain", 10);

    // Backpressure: router stalls, port 0 ni sends one cycle after seeing ready.
    do_reset();
    up_ready_in = 1'b0;
    r = 1'b1;
    npush = 0;
    for (int it = 0; it < 12; it++) begin
      tick();
      if (up_valid_out) check("bp_hold", up_data_out, 16'h0100);
      ni_valid_in[0] = r;
      if (r) begin
        ni_data_in[DW-1:0] = 16'h0100 + 16'(npush);
        up_q.push_back(16'h0100 + 16'(npush));
        npush++;
      end
      @(negedge clk);
      r = ni_ready_out[0];
    end
    ni_valid_in = '0;
    tick();
    check("bp_ready0", ni_ready_out[0], 0);
    check("bp_npush", npush, BD + 1);
    check("bp_valid", up_valid_out, 1);
    check("bp_data", up_data_out, 16'h0100);
    up_ready_in = 1'b1;
    drain("bp_drain", 20);
    check("bp_ready_after", ni_ready_out, 4'hF);

    // Downlink steering, back-to-back to every leaf.
    tick();
    down_valid_in = 1'b1;
    down_data_in  = 16'h3B21;
    dn_q.push_back({4'b0100, 16'h3B21});
    tick();
    check("dn_vec", ni_valid_out, 4'b0100);
    check("dn_dat2", ni_data_out[2*DW +: DW], 16'h3B21);
    down_data_in = 16'h3C77;
    dn_q.push_back({4'b1000, 16'h3C77});
    tick();
    down_data_in = 16'h3477;
    dn_q.push_back({4'b0010, 16'h3477});
    tick();
    down_data_in = 16'h3000;
    dn_q.push_back({4'b0001, 16'h3000});
    tick();
    down_valid_in = 1'b0;
    tick();
    check("dn_idle", ni_valid_out, 0);
    check("dn_drop0", drop_count, 0);

    // Misroute: group 4 flits are dropped, count saturates.
    down_valid_in = 1'b1;
    down_data_in  = 16'h4B21;
    repeat (10) tick();
    check("drop10", drop_count, 10);
    repeat (290) tick();
    down_valid_in = 1'b0;
    tick();
    check("drop_sat", drop_count, 255);
    check("drop_no_pulse", ni_valid_out, 0);

    tick();
    check("dn_q_empty", dn_q.size(), 0);
    check("up_q_empty", up_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
